// File: rtl/mult_pkg.sv
// Shared parameters and types for the multiplier's final carry-propagate stage.
package mult_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SEG   = 8;
  localparam int unsigned NSEG  = WIDTH / SEG;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(NSEG);

endpackage

// File: rtl/cs_final_adder_if.sv
// Operand-in / result-out valid-ready bundle for cs_final_adder.
interface cs_final_adder_if #(
  parameter int unsigned WIDTH = mult_pkg::WIDTH
);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] carry_in;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] prod;
  logic             cout;

  modport master (
    output s_valid, sum_in, carry_in, m_ready,
    input  s_ready, m_valid, prod, cout
  );

  modport slave (
    input  s_valid, sum_in, carry_in, m_ready,
    output s_ready, m_valid, prod, cout
  );

endinterface

// File: rtl/compressor_3_2.sv
// 3:2 compressor (full adder) cell.
module compressor_3_2 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/seg_cpa.sv
// SEG-bit ripple-carry adder built from a chain of 3:2 compressor cells.
module seg_cpa #(
  parameter int unsigned SEG = mult_pkg::SEG
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout
);

  logic [SEG:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < SEG; g++) begin : g_bit
    compressor_3_2 u_fa (
      .i_a    (i_a[g]),
      .i_b    (i_b[g]),
      .i_c    (w_c[g]),
      .o_sum  (o_sum[g]),
      .o_carry(w_c[g+1])
    );
  end

  assign o_cout = w_c[SEG];

endmodule

// File: rtl/cs_final_adder.sv
// Resolves a carry-save pair into a binary result, SEG bits per cycle, with a
// registered carry between segments; one pair in flight at a time.
module cs_final_adder
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = mult_pkg::WIDTH,
  parameter int unsigned SEG   = mult_pkg::SEG
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  cs_final_adder_if.slave bus
);

  localparam int unsigned NumSeg = WIDTH / SEG;
  localparam int unsigned CntW   = cnt_width(NumSeg);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSeg - 1);

  state_e           r_state;
  logic [CntW-1:0]  r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_prod;
  logic             r_cout;
  logic             r_s_ready;
  logic             r_m_valid;

  logic [SEG-1:0]   w_seg_a;
  logic [SEG-1:0]   w_seg_b;
  logic [SEG-1:0]   w_seg_sum;
  logic             w_seg_cout;

  // Single adder shared across segments; r_cnt steers the operand slice.
  assign w_seg_a = r_a[r_cnt*SEG +: SEG];
  assign w_seg_b = r_b[r_cnt*SEG +: SEG];

  seg_cpa #(
    .SEG(SEG)
  ) u_seg_cpa (
    .i_a   (w_seg_a),
    .i_b   (w_seg_b),
    .i_cin (r_carry),
    .o_sum (w_seg_sum),
    .o_cout(w_seg_cout)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_prod    <= '0;
      r_cout    <= 1'b0;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.s_valid) begin
            r_a       <= bus.sum_in;
            r_b       <= bus.carry_in;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_s_ready <= 1'b0;
            r_state   <= StAdd;
          end
        end
        StAdd: begin
          r_prod[r_cnt*SEG +: SEG] <= w_seg_sum;
          r_carry                  <= w_seg_cout;
          r_cnt                    <= r_cnt + CntW'(1);
          if (r_cnt == LastCnt) begin
            r_cout    <= w_seg_cout;
            r_m_valid <= 1'b1;
            r_state   <= StDone;
          end
        end
        StDone: begin
          if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.s_ready = r_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.prod    = r_prod;
  assign bus.cout    = r_cout;

endmodule

// File: tb/tb_cs_final_adder.sv
// Directed bench for cs_final_adder: latency, carry ripple, backpressure,
// asynchronous reset mid-operation and back-to-back throughput.
module tb_cs_final_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cs_final_adder_if bus ();

  cs_final_adder dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (bus.slave)
  );

  // Offer a pair from a negedge; returns at the negedge following acceptance.
  task automatic accept_pair(input logic [31:0] s, input logic [31:0] c, output bit ok);
    bus.s_valid  = 1'b1;
    bus.sum_in   = s;
    bus.carry_in = c;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.s_ready) ok = 1'b1;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
  endtask

  // Counts negedges from the offering negedge until m_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1) begin
      failures++; $display("FAIL reset_s_ready got=%b want=1", bus.s_ready);
    end
    checks++;
    if (bus.m_valid !== 1'b0) begin
      failures++; $display("FAIL reset_m_valid got=%b want=0", bus.m_valid);
    end
    checks++;
    if (bus.prod !== 32'h0 || bus.cout !== 1'b0) begin
      failures++; $display("FAIL reset_prod got=%h/%b want=0/0", bus.prod, bus.cout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vector(input string nm, input logic [31:0] s, input logic [31:0] c,
                             input logic [31:0] exp_p, input logic exp_c);
    bit ok;
    int n;
    accept_pair(s, c, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL %s_accept got=0 want=1", nm);
    end
    wait_valid(n);
    checks++;
    if (n !== 5) begin
      failures++; $display("FAIL %s_latency got=%0d want=5", nm, n);
    end
    checks++;
    if (bus.prod !== exp_p || bus.cout !== exp_c) begin
      failures++;
      $display("FAIL %s_result got=%h/%b want=%h/%b", nm, bus.prod, bus.cout, exp_p, exp_c);
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_handshake got=v%b/r%b want=v0/r1", nm, bus.m_valid, bus.s_ready);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    int bad;
    accept_pair(32'h1234_5678, 32'h1111_1111, ok);
    wait_valid(n);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.m_valid !== 1'b1 || bus.prod !== 32'h2345_6789 || bus.s_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || n != 5) begin
      failures++; $display("FAIL backpressure_hold got=%0d_bad_cycles want=0", bad);
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release got=v%b/r%b want=v0/r1", bus.m_valid, bus.s_ready);
    end
  endtask

  task automatic test_reset_mid_add();
    bit ok;
    int seen;
    accept_pair(32'h0000_00F0, 32'h0000_000F, ok);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.prod !== 32'h0) begin
      failures++;
      $display("FAIL midreset_clear got=v%b/r%b/p%h want=v0/r1/p0", bus.m_valid, bus.s_ready,
               bus.prod);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.m_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL midreset_discard got=%0d want=0", seen);
    end
    test_vector("after_reset", 32'h0F0F_0F0F, 32'h0101_0101, 32'h1010_1010, 1'b0);
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int rc[$];
    logic [31:0] rp[$];
    logic rco[$];
    bit switch_pending;
    switch_pending = 1'b0;
    bus.m_ready  = 1'b1;
    bus.s_valid  = 1'b1;
    bus.sum_in   = 32'h8000_0000;
    bus.carry_in = 32'h8000_0001;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (switch_pending) begin
        switch_pending = 1'b0;
        if (acc.size() == 1) begin
          bus.sum_in   = 32'h00FF_00FF;
          bus.carry_in = 32'h0001_0001;
        end else begin
          bus.s_valid = 1'b0;
        end
      end
      if (bus.m_valid) begin
        rc.push_back(cyc); rp.push_back(bus.prod); rco.push_back(bus.cout);
      end
      if (bus.s_valid && bus.s_ready) begin
        acc.push_back(cyc);
        switch_pending = 1'b1;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    checks++;
    if (acc.size() != 2 || rc.size() != 2) begin
      failures++;
      $display("FAIL b2b_counts got=%0d/%0d want=2/2", acc.size(), rc.size());
    end else begin
      checks++;
      if (acc[1] - acc[0] != 6) begin
        failures++; $display("FAIL b2b_accept_gap got=%0d want=6", acc[1] - acc[0]);
      end
      checks++;
      if (rc[1] - rc[0] != 6 || rc[0] - acc[0] != 5) begin
        failures++;
        $display("FAIL b2b_result_gap got=%0d/%0d want=6/5", rc[1] - rc[0], rc[0] - acc[0]);
      end
      checks++;
      if (rp[0] !== 32'h0000_0001 || rco[0] !== 1'b1) begin
        failures++; $display("FAIL b2b_first got=%h/%b want=00000001/1", rp[0], rco[0]);
      end
      checks++;
      if (rp[1] !== 32'h0100_0100 || rco[1] !== 1'b0) begin
        failures++; $display("FAIL b2b_second got=%h/%b want=01000100/0", rp[1], rco[1]);
      end
    end
  endtask

  initial begin
    bus.s_valid  = 1'b0;
    bus.sum_in   = '0;
    bus.carry_in = '0;
    bus.m_ready  = 1'b0;
    test_reset();
    test_vector("basic", 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0);
    test_vector("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    test_vector("product", 32'h0625_0060, 32'h0001_0000, 32'h0626_0060, 1'b0);
    test_backpressure();
    test_reset_mid_add();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cs_final_adder.md
# cs_final_adder

Sequential carry-propagate resolver at the output of the Booth-4 Wallace-tree multiplier. Accepts one carry-save operand pair (sum vector, carry vector) produced by the final compressor row through a valid/ready handshake. Adds the pair segment by segment, SEG bits per cycle, with a registered carry between segments. Returns the binary product through a second valid/ready handshake. Trades latency for a short critical path, so the tree and the final adder can close timing at a higher clock.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of SEG.
- SEG, 8, bits resolved per cycle; NSEG = WIDTH/SEG.
- sys_clk  input  1  clock; all state changes on the rising edge.
- sys_rst  input  1  reset, asynchronous, active-high.
- s_valid  input  1  upstream pair valid.
- s_ready  output  1  block can accept a pair.
- sum_in  input  WIDTH  carry-save sum vector.
- carry_in  input  WIDTH  carry-save carry vector, already aligned to sum weight (the tree shifts left by 1 before presenting).
- m_valid  output  1  result valid.
- m_ready  input  1  downstream accepts result.
- prod  output  WIDTH  (sum_in + carry_in) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

## Operation
- FSM states:
  - IDLE: s_ready=1. On s_valid&&s_ready, latch sum_in and carry_in, clear the segment counter and the carry register, go to ADD.
  - ADD: each cycle, add segment cnt of both operands plus the carry register into prod[cnt*SEG +: SEG], then update the carry register and increment cnt. After the segment cnt==NSEG-1 is added, load cout from the final carry and go to DONE.
  - DONE: m_valid=1, and prod and cout are held stable. On m_valid&&m_ready, go to IDLE.
- Only one pair is in flight at a time. s_ready=0 in ADD and DONE, and s_valid is ignored there.
- Arithmetic is unsigned modulo 2^WIDTH. Two's-complement products come out correct in the low WIDTH bits. cout is informational only.
- m_valid must not drop before the handshake completes. prod and cout must not change while m_valid=1.
- Segment 0 carry-in is always 0.

## Timing
- Reset values:
  - state=IDLE, s_ready=1, m_valid=0, prod=0, cout=0.
  - Counter, carry register and operand registers all 0.
- Latency:
  - Acceptance edge E.
  - Segments are computed on edges E+1 .. E+NSEG.
  - m_valid=1 in the cycle after edge E+NSEG, which is cycle 5 after acceptance for the defaults.
- Throughput: at most one result per NSEG+2 cycles when m_ready is held high. This covers acceptance, NSEG ADD cycles and one DONE cycle.
- m_ready may be high before m_valid. The handshake completes in the first DONE cycle, and s_ready returns to 1 on the next cycle.
- Backpressure: with m_ready=0 the block stays in DONE indefinitely.
- Reset asserted mid-ADD or mid-DONE: all state clears immediately and asynchronously. The pending result is discarded and never presented.
- Carry ripples across every segment boundary. The all-ones + 1 case must propagate through all NSEG registered carries.

## Structure
- Shared package (mult_pkg) holds:
  - WIDTH and SEG defaults, plus NSEG derived as WIDTH/SEG.
  - The state enumeration: IDLE, ADD, DONE.
  - Counter width, $clog2(NSEG) with a minimum of 1.
- One sub-module: seg_cpa, an SEG-bit ripple adder with cin and cout built from compressor_3_2 full-adder cells. It is instantiated once and fed through the segment mux each cycle.
- Top level holds the FSM, counter, operand registers, carry register and result register.

## Test plan
- sum_in=0x000000FF, carry_in=0x00000001 -> prod=0x00000100, cout=0. m_valid first high 5 cycles after acceptance.
- sum_in=0xFFFFFFFF, carry_in=0x00000001 -> prod=0x00000000, cout=1. Checks full carry ripple across all 4 segments.
- 16x16 product 0x1234*0x5678 given as sum_in=0x06250060, carry_in=0x00010000 -> prod=0x06260060, cout=0.
- m_ready held 0 for 10 cycles after m_valid:
  - prod and m_valid stay stable and s_ready stays 0 throughout.
  - When m_ready rises, the handshake completes in that cycle and s_ready=1 on the next.
- sys_rst pulsed during ADD cnt=2 -> immediately state IDLE, m_valid=0, prod=0, s_ready=1. A new pair issued afterwards resolves correctly.
- Back-to-back pairs with s_valid held high and m_ready=1, with a second pair offered while busy:
  - The second pair is not accepted until s_ready=1.
  - Two results arrive 6 cycles apart with correct values.
